// File: rtl/cluster_eoc_responder_pkg.sv
// Shared constants and types for the cluster EOC responder.
// Optional timestamp registers are enabled by defining EOC_TIMESTAMP_EN.
package cluster_eoc_responder_pkg;

    localparam int unsigned EOC_COUNT_WIDTH = 16;
    localparam int unsigned EOC_CYCLE_WIDTH = 32;
    localparam int unsigned EOC_OFF_WIDTH   = 3;

    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_STATUS = 3'd0;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_SET    = 3'd1;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_CLEAR  = 3'd2;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_MASK   = 3'd3;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_CTRL   = 3'd4;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_COUNT  = 3'd5;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_CYCLE  = 3'd6;
    localparam logic [EOC_OFF_WIDTH-1:0] EOC_REG_TSTAMP = 3'd7;

    typedef enum logic {EOC_RUN, EOC_DONE} eoc_state_e;

    // Decoded read result before it enters the response register.
    typedef struct packed {
        logic        opc;
        logic [31:0] rdata;
    } eoc_rsp_t;

    // Expand byte enables into a 32-bit bit mask.
    function automatic logic [31:0] eoc_be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/cluster_eoc_responder_fsm.sv
// RUN/DONE state machine, DONE-entry counter and irq pulse for the EOC responder.
// Defining EOC_TIMESTAMP_EN adds a free-running cycle counter and a DONE-entry timestamp.
module cluster_eoc_fsm
    import cluster_eoc_responder_pkg::*;
#(
    parameter int unsigned NB_CORES = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable,
    input  logic [NB_CORES-1:0]        status,
    input  logic [NB_CORES-1:0]        mask,
    input  logic                       leave,
    output logic                       trigger_c,
    output logic                       eoc,
    output logic                       irq,
    output logic [EOC_COUNT_WIDTH-1:0] count
`ifdef EOC_TIMESTAMP_EN
    ,
    output logic [EOC_CYCLE_WIDTH-1:0] cycle,
    output logic [EOC_CYCLE_WIDTH-1:0] tstamp
`endif
);

    eoc_state_e state;

    assign trigger_c = (state == EOC_RUN) && enable && (|mask) && ((status & mask) == mask);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= EOC_RUN;
            eoc   <= 1'b0;
            irq   <= 1'b0;
            count <= '0;
        end else begin
            irq <= 1'b0;
            case (state)
                EOC_RUN: begin
                    if (trigger_c) begin
                        state <= EOC_DONE;
                        eoc   <= 1'b1;
                        irq   <= 1'b1;
                        if (count != '1) count <= count + EOC_COUNT_WIDTH'(1);
                    end
                end
                EOC_DONE: begin
                    if (leave) begin
                        state <= EOC_RUN;
                        eoc   <= 1'b0;
                    end
                end
                default: begin
                    state <= EOC_RUN;
                    eoc   <= 1'b0;
                end
            endcase
        end
    end

`ifdef EOC_TIMESTAMP_EN
    // Timestamp captures the counter value seen in the cycle the transition is decided.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cycle  <= '0;
            tstamp <= '0;
        end else begin
            cycle <= cycle + EOC_CYCLE_WIDTH'(1);
            if (trigger_c) tstamp <= cycle;
        end
    end
`endif

endmodule

// File: rtl/cluster_eoc_responder.sv
// Peripheral-bus slave collecting per-core EOC writes into a cluster EOC level and irq.
// Defining EOC_TIMESTAMP_EN maps the CYCLE and TSTAMP read-only registers.
module cluster_eoc_responder
    import cluster_eoc_responder_pkg::*;
#(
    parameter int unsigned NB_CORES   = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            be_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_opc_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic                  eoc_o,
    output logic                  eoc_irq_o
);

    logic [NB_CORES-1:0]        status_q, mask_q, wbits, bemask, auto_clr;
    logic                       en_q, sticky_q;
    logic [EOC_OFF_WIDTH-1:0]   off;
    logic                       wr, set_we, clr_we, mask_we, ctrl_we, leave, trigger;
    logic [EOC_COUNT_WIDTH-1:0] count;
    eoc_rsp_t                   rsp;
    logic                       unused_addr;
`ifdef EOC_TIMESTAMP_EN
    logic [EOC_CYCLE_WIDTH-1:0] cycle, tstamp;
`endif

    assign gnt_o       = req_i;
    assign off         = add_i[4:2];
    assign wr          = req_i && !wen_i;
    assign bemask      = NB_CORES'(eoc_be_mask(be_i));
    assign wbits       = NB_CORES'(wdata_i & eoc_be_mask(be_i));
    assign unused_addr = ^{add_i[ADDR_WIDTH-1:5], add_i[1:0]};

    // Address decode: read data, error flag and write strobes.
    always_comb begin
        rsp     = '0;
        set_we  = 1'b0;
        clr_we  = 1'b0;
        mask_we = 1'b0;
        ctrl_we = 1'b0;
        case (off)
            EOC_REG_STATUS: begin
                if (wr) rsp.opc = 1'b1;
                else    rsp.rdata = 32'(status_q);
            end
            EOC_REG_SET:   set_we = wr;
            EOC_REG_CLEAR: clr_we = wr;
            EOC_REG_MASK: begin
                mask_we   = wr;
                rsp.rdata = 32'(mask_q);
            end
            EOC_REG_CTRL: begin
                ctrl_we   = wr;
                rsp.rdata = {30'd0, sticky_q, en_q};
            end
            EOC_REG_COUNT: begin
                if (wr) rsp.opc = 1'b1;
                else    rsp.rdata = 32'(count);
            end
`ifdef EOC_TIMESTAMP_EN
            EOC_REG_CYCLE: begin
                if (wr) rsp.opc = 1'b1;
                else    rsp.rdata = cycle;
            end
            EOC_REG_TSTAMP: begin
                if (wr) rsp.opc = 1'b1;
                else    rsp.rdata = tstamp;
            end
`endif
            default: rsp.opc = 1'b1;
        endcase
    end

    assign leave    = clr_we || (ctrl_we && be_i[0] && !wdata_i[0]);
    assign auto_clr = (trigger && !sticky_q) ? mask_q : '0;

    // Register file; a core SET overrides the auto-clear of the same bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            status_q <= '0;
            mask_q   <= '1;
            en_q     <= 1'b1;
            sticky_q <= 1'b0;
        end else begin
            status_q <= (status_q & ~auto_clr & ~(clr_we ? wbits : '0)) | (set_we ? wbits : '0);
            if (mask_we) mask_q <= (mask_q & ~bemask) | wbits;
            if (ctrl_we && be_i[0]) begin
                en_q     <= wdata_i[0];
                sticky_q <= wdata_i[1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_opc_o   <= 1'b0;
            r_rdata_o <= '0;
            r_id_o    <= '0;
        end else begin
            r_valid_o <= req_i;
            r_opc_o   <= req_i && rsp.opc;
            r_rdata_o <= (req_i && wen_i && !rsp.opc) ? DATA_WIDTH'(rsp.rdata) : '0;
            if (req_i) r_id_o <= id_i;
        end
    end

    cluster_eoc_fsm #(
        .NB_CORES (NB_CORES)
    ) i_fsm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable    (en_q),
        .status    (status_q),
        .mask      (mask_q),
        .leave     (leave),
        .trigger_c (trigger),
        .eoc       (eoc_o),
        .irq       (eoc_irq_o),
        .count     (count)
`ifdef EOC_TIMESTAMP_EN
        ,
        .cycle     (cycle),
        .tstamp    (tstamp)
`endif
    );

endmodule
